fibonacci_calculator_gen: RTL and testbench
===========================================

Name: fibonacci_calculator_gen

Overview:
Parametrised next-generation sequence calculator replacing the fixed 16-bit/5-bit Fibonacci calculator.
- Computes term n of a Fibonacci-type sequence iteratively, one addition per clock.
- Adds a selectable Lucas mode, overflow detection with optional saturation, and a busy indication.
- Sits as a start/done-controlled arithmetic unit behind a simple host handshake.
- Bench-compatible with the existing calculator at default parameters.

Parameters:
WIDTH, 16, result/accumulator width in bits
IDX_W, 5, index input width; n range 0..2^IDX_W-1
SATURATE, 1, 1 = clamp result to all-ones on overflow; 0 = wrap modulo 2^WIDTH

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
input_s  in  IDX_W  term index n, sampled on accept
mode  in  1  0 = Fibonacci seeds (1,1); 1 = Lucas seeds (2,1); sampled on accept
begin_fibo  in  1  start request
busy  out  1  high while computing
done  out  1  high while a valid result is held
overflow  out  1  result term exceeded WIDTH bits; valid when done=1
fibo_out  out  WIDTH  result S(n); valid when done=1

Behaviour:
- Sequence: S(0)=s0, S(1)=s1, S(k)=S(k-1)+S(k-2).
  - Fibonacci: n=0,1,2,3 -> 1,1,2,3; S(n)=F(n+1).
  - Lucas: 2,1,3,4,7,11...
- Reset (async, reset=0):
  - state=IDLE; busy=0, done=0, overflow=0, fibo_out=0.
  - All internal registers cleared immediately, including mid-computation.
  - Leaving reset needs no begin edge.
- States:
  - IDLE: begin_fibo=1 at a rising edge accepts. Load a=s0, b=s1, cnt=input_s, a_ovf=b_ovf=0. Go to CALC.
  - CALC (busy=1):
    - cnt==0: fibo_out<=a (or all-ones if a_ovf and SATURATE), overflow<=a_ovf, go to DONE.
    - else: a<=b, b<=a+b (WIDTH-bit, wraps), a_ovf<=b_ovf, b_ovf<=b_ovf|carry_out, cnt<=cnt-1.
  - DONE (done=1): hold fibo_out and overflow. begin_fibo=1 accepts a new request exactly as in IDLE. done falls and busy rises on that same edge.
- Latency: done is first high after rising edge n+1 counted from the accepting edge (edge 0). Cycle count is exactly n+1, independent of mode.
- begin_fibo while busy: ignored; input_s/mode changes during CALC have no effect.
- Overflow is tracked per term, so a carry in the look-ahead term b never flags a result that fits.
- fibo_out and overflow are stable from done rising until the next accept. Between accept and done they are don't-care; the implementation holds the old values.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Package fib_pkg: state enum (IDLE, CALC, DONE), mode enum (MODE_FIB=0, MODE_LUCAS=1), seed constants FIB_S0=1, FIB_S1=1, LUC_S0=2, LUC_S1=1.
- Single module; no sub-module. The adder with carry-out is inline, one (WIDTH+1)-bit addition.

Test Plan:
- Defaults, Fibonacci, n=0..23, reset pulse before each run -> fibo_out matches 1,1,2,...,46368; done after exactly n+1 cycles; overflow=0.
- Fibonacci n=24 -> true value 75025 overflows: overflow=1, fibo_out=65535. With SATURATE=0, fibo_out=9489.
- Lucas n=0 -> 2; n=5 -> 11; n=23 -> 64079, overflow=0. Latency identical to Fibonacci.
- n=10 started; at cycle 4 pulse begin_fibo with n=3 -> ignored; result 89 after 11 cycles. Then begin in DONE with n=3 -> done drops next edge, result 3 after 4 cycles.
- Assert reset=0 mid-CALC (n=20, cycle 7) -> busy/done/overflow/fibo_out=0 immediately, asynchronously. After release, state IDLE with done=0 until a new begin_fibo.
- WIDTH=32, IDX_W=6, Fibonacci n=46 -> 2971215073 with no overflow; n=47 -> overflow=1, fibo_out=32'hFFFFFFFF.

Source files
------------

// File: rtl/fib_pkg.sv
// -----------------------------------------------------------------------------
// fib_pkg
// Shared types and constants for the Fibonacci/Lucas sequence calculator.
//   state_e : controller states (IDLE, CALC, DONE)
//   mode_e  : seed selection (MODE_FIB = 0, MODE_LUCAS = 1)
//   *_S0/_S1: seed terms S(0), S(1) for each mode
// -----------------------------------------------------------------------------
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_FIB   = 1'b0,
    MODE_LUCAS = 1'b1
  } mode_e;

  localparam int unsigned FIB_S0 = 1;
  localparam int unsigned FIB_S1 = 1;
  localparam int unsigned LUC_S0 = 2;
  localparam int unsigned LUC_S1 = 1;

endpackage : fib_pkg

// File: rtl/fibonacci_calculator_gen.sv
// -----------------------------------------------------------------------------
// fibonacci_calculator_gen
// Iterative calculator for term S(n) of a Fibonacci-type sequence, one
// addition per clock. Fibonacci seeds (1,1) give S(n) = F(n+1); Lucas seeds
// (2,1) give the Lucas numbers. Overflow is tracked per term; with SATURATE=1
// an overflowed result is clamped to all-ones, otherwise it wraps.
//
// Parameters:
//   WIDTH    result / accumulator width
//   IDX_W    index width, n in 0 .. 2^IDX_W-1
//   SATURATE 1 = clamp on overflow, 0 = wrap modulo 2^WIDTH
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   input_s    term index n, sampled when a request is accepted
//   mode       0 = Fibonacci, 1 = Lucas, sampled when a request is accepted
//   begin_fibo start request, accepted in IDLE or DONE
//   busy       high while computing
//   done       high while a valid result is held
//   overflow   result term exceeded WIDTH bits (valid with done)
//   fibo_out   result S(n) (valid with done)
//
// Latency: done rises n+1 clocks after the accepting edge. All outputs are
// registered.
// -----------------------------------------------------------------------------
module fibonacci_calculator_gen
  import fib_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int IDX_W    = 5,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] input_s,
  input  logic             mode,
  input  logic             begin_fibo,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [WIDTH-1:0] fibo_out
);

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;        // current term S(k)
  logic [WIDTH-1:0]   b_q;        // look-ahead term S(k+1)
  logic               a_ovf_q;    // S(k) has exceeded WIDTH bits
  logic               b_ovf_q;    // S(k+1) has exceeded WIDTH bits
  logic [IDX_W-1:0]   cnt_q;      // remaining steps
  logic               busy_q;
  logic               done_q;
  logic               overflow_q;
  logic [WIDTH-1:0]   fibo_out_q;

  logic [WIDTH:0]     sum_d;      // a+b with carry-out in the MSB
  logic [WIDTH-1:0]   seed0_d;
  logic [WIDTH-1:0]   seed1_d;

  always_comb begin
    sum_d = {1'b0, a_q} + {1'b0, b_q};
    if (mode_e'(mode) == MODE_LUCAS) begin
      seed0_d = WIDTH'(LUC_S0);
      seed1_d = WIDTH'(LUC_S1);
    end else begin
      seed0_d = WIDTH'(FIB_S0);
      seed1_d = WIDTH'(FIB_S1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      a_ovf_q    <= 1'b0;
      b_ovf_q    <= 1'b0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      fibo_out_q <= '0;
    end else begin
      case (state_q)
        // IDLE and DONE accept a request identically; the held result stays
        // on fibo_out/overflow until the next completion.
        IDLE, DONE: begin
          if (begin_fibo) begin
            a_q     <= seed0_d;
            b_q     <= seed1_d;
            a_ovf_q <= 1'b0;
            b_ovf_q <= 1'b0;
            cnt_q   <= input_s;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            state_q <= CALC;
          end
        end

        CALC: begin
          if (cnt_q == '0) begin
            fibo_out_q <= (a_ovf_q && SATURATE) ? '1 : a_q;
            overflow_q <= a_ovf_q;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= DONE;
          end else begin
            // Shift the window forward one term. Overflow flags travel with
            // their terms so a carry in the look-ahead term never flags a
            // result that fits.
            a_q     <= b_q;
            b_q     <= sum_d[WIDTH-1:0];
            a_ovf_q <= b_ovf_q;
            b_ovf_q <= b_ovf_q | sum_d[WIDTH];
            cnt_q   <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign fibo_out = fibo_out_q;

endmodule : fibonacci_calculator_gen

// File: tb/tb_fibonacci_calculator_gen.sv
// -----------------------------------------------------------------------------
// tb_fibonacci_calculator_gen
// Scoreboard bench. Three instances share clock and reset:
//   u_dut  : defaults (WIDTH=16, IDX_W=5, SATURATE=1)
//   u_wrap : SATURATE=0, same inputs as u_dut (lock-step)
//   u_wide : WIDTH=32, IDX_W=6, own request inputs
// The driver pushes hand-computed expectations; monitors pop on each rising
// done and compare result, overflow and start-to-done latency.
// -----------------------------------------------------------------------------
module tb_fibonacci_calculator_gen;

  logic        clk;
  logic        reset;
  logic [4:0]  input_s;
  logic        mode;
  logic        begin_fibo;
  logic        busy, done, overflow;
  logic [15:0] fibo_out;
  logic        busy_r, done_r, overflow_r;
  logic [15:0] fibo_r;
  logic [5:0]  input_w;
  logic        mode_w;
  logic        begin_w;
  logic        busy_w, done_w, overflow_w;
  logic [31:0] fibo_w;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [15:0] fibo;
    logic        ovf;
    logic [15:0] wfibo;
    logic        wovf;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] fibo;
    logic        ovf;
    int          lat;
  } expw_t;

  exp_t  exp_q[$];
  expw_t expw_q[$];

  // F(n+1) for n = 0..23
  int fib_tab[24] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377,
                      610, 987, 1597, 2584, 4181, 6765, 10946, 17711, 28657,
                      46368};

  fibonacci_calculator_gen u_dut (
    .clk(clk), .reset(reset), .input_s(input_s), .mode(mode),
    .begin_fibo(begin_fibo), .busy(busy), .done(done),
    .overflow(overflow), .fibo_out(fibo_out)
  );

  fibonacci_calculator_gen #(.WIDTH(16), .IDX_W(5), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .input_s(input_s), .mode(mode),
    .begin_fibo(begin_fibo), .busy(busy_r), .done(done_r),
    .overflow(overflow_r), .fibo_out(fibo_r)
  );

  fibonacci_calculator_gen #(.WIDTH(32), .IDX_W(6), .SATURATE(1'b1)) u_wide (
    .clk(clk), .reset(reset), .input_s(input_w), .mode(mode_w),
    .begin_fibo(begin_w), .busy(busy_w), .done(done_w),
    .overflow(overflow_w), .fibo_out(fibo_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor for u_dut / u_wrap
  initial begin
    logic busy_p, done_p;
    int   start_cyc;
    exp_t e;
    busy_p = 1'b0; done_p = 1'b0; start_cyc = 0;
    forever begin
      @(negedge clk);
      if (busy && !busy_p) start_cyc = cyc;
      if (done && !done_p) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'(done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("fibo_out", 64'(fibo_out), 64'(e.fibo));
          check("overflow", 64'(overflow), 64'(e.ovf));
          check("latency", 64'(cyc - start_cyc), 64'(e.lat));
          check("wrap_done", 64'(done_r), 64'd1);
          check("wrap_fibo_out", 64'(fibo_r), 64'(e.wfibo));
          check("wrap_overflow", 64'(overflow_r), 64'(e.wovf));
          $display("main: fibo_out=%0d overflow=%0b lat=%0d wrap=%0d",
                   fibo_out, overflow, cyc - start_cyc, fibo_r);
        end
      end
      busy_p = busy;
      done_p = done;
    end
  end

  // Monitor for u_wide
  initial begin
    logic  busy_p, done_p;
    int    start_cyc;
    expw_t e;
    busy_p = 1'b0; done_p = 1'b0; start_cyc = 0;
    forever begin
      @(negedge clk);
      if (busy_w && !busy_p) start_cyc = cyc;
      if (done_w && !done_p) begin
        if (expw_q.size() == 0) begin
          check("wide_unexpected_done", 64'(done_w), 64'd0);
        end else begin
          e = expw_q.pop_front();
          check("wide_fibo_out", 64'(fibo_w), 64'(e.fibo));
          check("wide_overflow", 64'(overflow_w), 64'(e.ovf));
          check("wide_latency", 64'(cyc - start_cyc), 64'(e.lat));
          $display("wide: fibo_out=%0d overflow=%0b lat=%0d",
                   fibo_w, overflow_w, cyc - start_cyc);
        end
      end
      busy_p = busy_w;
      done_p = done_w;
    end
  end

  // Assert reset between clock edges; outputs must clear without a clock.
  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("reset_outputs", {44'd0, busy, done, overflow, fibo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_main(input int n, input bit m);
    @(negedge clk);
    input_s    = n[4:0];
    mode       = m;
    begin_fibo = 1'b1;
    @(negedge clk);
    begin_fibo = 1'b0;
  endtask

  task automatic push_main(input int f, input bit o, input int wf,
                           input bit wo, input int lat);
    exp_t e;
    e.fibo = f[15:0]; e.ovf = o; e.wfibo = wf[15:0]; e.wovf = wo; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_done_main(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 64'(seen), 64'd1);
  endtask

  task automatic run_wide(input int n, input logic [31:0] f, input bit o);
    expw_t e;
    bit seen;
    e.fibo = f; e.ovf = o; e.lat = n + 1;
    expw_q.push_back(e);
    @(negedge clk);
    input_w = n[5:0];
    mode_w  = 1'b0;
    begin_w = 1'b1;
    @(negedge clk);
    begin_w = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done_w) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("wide_done_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    reset = 1'b0; input_s = '0; mode = 1'b0; begin_fibo = 1'b0;
    input_w = '0; mode_w = 1'b0; begin_w = 1'b0;
    #3 check("reset_initial", {44'd0, busy, done, overflow, fibo_out}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Fibonacci sweep n = 0..23, reset before each run
    for (int n = 0; n < 24; n++) begin
      do_reset();
      push_main(fib_tab[n], 1'b0, fib_tab[n], 1'b0, n + 1);
      start_main(n, 1'b0);
      wait_done_main("fib_done_timeout");
    end

    // Fibonacci n=24: 75025 overflows 16 bits
    push_main(65535, 1'b1, 9489, 1'b1, 25);
    start_main(24, 1'b0);
    wait_done_main("ovf_done_timeout");

    // Lucas terms
    push_main(2, 1'b0, 2, 1'b0, 1);
    start_main(0, 1'b1);
    wait_done_main("luc0_done_timeout");
    push_main(11, 1'b0, 11, 1'b0, 6);
    start_main(5, 1'b1);
    wait_done_main("luc5_done_timeout");
    push_main(64079, 1'b0, 64079, 1'b0, 24);
    start_main(23, 1'b1);
    wait_done_main("luc23_done_timeout");

    // begin_fibo while busy is ignored; input changes during CALC too
    push_main(89, 1'b0, 89, 1'b0, 11);
    start_main(10, 1'b0);
    repeat (3) @(negedge clk);
    input_s = 5'd3; begin_fibo = 1'b1;
    @(negedge clk);
    begin_fibo = 1'b0; input_s = 5'd7; mode = 1'b1;
    wait_done_main("ignore_done_timeout");

    // Restart directly from DONE: done falls and busy rises on the accept edge
    push_main(3, 1'b0, 3, 1'b0, 4);
    @(negedge clk);
    input_s = 5'd3; mode = 1'b0; begin_fibo = 1'b1;
    @(posedge clk);
    #1 check("restart_done_low", 64'(done), 64'd0);
    check("restart_busy_high", 64'(busy), 64'd1);
    @(negedge clk);
    begin_fibo = 1'b0;
    wait_done_main("restart_done_timeout");

    // Asynchronous reset in the middle of a computation
    start_main(20, 1'b0);
    repeat (6) @(posedge clk);
    #2 check("busy_before_reset", 64'(busy), 64'd1);
    reset = 1'b0;
    #1 check("midcalc_reset", {44'd0, busy, done, overflow, fibo_out}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_idle", {62'd0, busy, done}, 64'd0);

    // Wide instance
    run_wide(46, 32'd2971215073, 1'b0);
    run_wide(47, 32'hFFFF_FFFF, 1'b1);

    repeat (3) @(negedge clk);
    check("main_queue_empty", 64'(exp_q.size()), 64'd0);
    check("wide_queue_empty", 64'(expw_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fibonacci_calculator_gen
